// File: rtl/isa_shared_pkg.sv
// Shared ISA definitions: immediate-op encodings, multicycle sequencer states
// and the program-counter step used by the controller.
package isa_shared_pkg;

  // Immediate formats reported by the decoder; IMM_NOP means no immediate.
  localparam logic [2:0] IMM_NOP = 3'd0;
  localparam logic [2:0] IMM_I   = 3'd1;
  localparam logic [2:0] IMM_S   = 3'd2;
  localparam logic [2:0] IMM_B   = 3'd3;
  localparam logic [2:0] IMM_U   = 3'd4;
  localparam logic [2:0] IMM_J   = 3'd5;

  // Sequencer phases of the multicycle controller.
  typedef enum logic [2:0] {
    MC_FETCH,
    MC_DECODE,
    MC_EXEC,
    MC_MEM,
    MC_WB,
    MC_TRAP
  } mc_state_t;

  // Byte distance between consecutive instructions.
  localparam int PC_STEP = 4;

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer. Owns pc, the instruction
// register and the operand/result latches, and runs the imem/dmem request
// handshakes so wait-stated memories are tolerated.
// Optional: define MULTICYCLE_CONTROL_PERF_EN to add perf_cycles/perf_retired.
module multicycle_control
  import isa_shared_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  localparam int                   RW         = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  input  logic [2:0]            dec_alu_op,
  input  logic [2:0]            dec_imm_op,
  input  logic                  dec_mem_read,
  input  logic                  dec_mem_write,
  input  logic                  dec_reg_write,
  input  logic [RW-1:0]         dec_rd,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [DATA_WIDTH-1:0] imm_data,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  rf_we,
  output logic [RW-1:0]         rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wdata,
`ifdef MULTICYCLE_CONTROL_PERF_EN
  output logic [DATA_WIDTH-1:0] perf_cycles,
  output logic [DATA_WIDTH-1:0] perf_retired,
`endif
  output logic                  trap
);

  mc_state_t             state;
  mc_state_t             next_state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] sd_q;
  logic [DATA_WIDTH-1:0] alu_q;
  logic [DATA_WIDTH-1:0] mdr;
  logic                  adv_pc;

  // The ALU takes its op straight from the decoder; EXEC is always one cycle.
  logic unused_alu_op;
  assign unused_alu_op = ^dec_alu_op;

  // Next-state decode plus all outputs; outputs depend only on registered
  // state, and requests are forced low while reset is held so memories see
  // an in-flight handshake abort immediately.
  always_comb begin
    next_state = state;
    adv_pc     = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    imem_addr  = pc;
    instr      = ir;
    alu_a      = a_q;
    alu_b      = b_q;
    dmem_addr  = alu_q;
    dmem_wdata = sd_q;
    rf_rd      = dec_rd;
    rf_wdata   = dec_mem_read ? mdr : alu_q;
    trap       = (state == MC_TRAP);
    case (state)
      MC_FETCH: begin
        imem_req = rst_n;
        if (imem_ready) next_state = MC_DECODE;
      end
      MC_DECODE: begin
        next_state = (dec_mem_read && dec_mem_write) ? MC_TRAP : MC_EXEC;
      end
      MC_EXEC: begin
        if (dec_mem_read || dec_mem_write) begin
          next_state = MC_MEM;
        end else if (dec_reg_write) begin
          next_state = MC_WB;
        end else begin
          next_state = MC_FETCH;
          adv_pc     = 1'b1;
        end
      end
      MC_MEM: begin
        dmem_req = rst_n;
        dmem_we  = rst_n && dec_mem_write;
        if (dmem_ready) begin
          if (dec_mem_read) begin
            next_state = MC_WB;
          end else begin
            next_state = MC_FETCH;
            adv_pc     = 1'b1;
          end
        end
      end
      MC_WB: begin
        rf_we      = (dec_rd != '0);
        next_state = MC_FETCH;
        adv_pc     = 1'b1;
      end
      MC_TRAP: begin
        next_state = MC_TRAP;
      end
      default: begin
        next_state = MC_FETCH;
      end
    endcase
  end

  // State, pc and the per-phase latches; each latch loads only in its phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MC_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sd_q  <= '0;
      alu_q <= '0;
      mdr   <= '0;
    end else begin
      state <= next_state;
      if (adv_pc) pc <= pc + DATA_WIDTH'(PC_STEP);
      case (state)
        MC_FETCH: begin
          if (imem_ready) ir <= imem_rdata;
        end
        MC_DECODE: begin
          if (!(dec_mem_read && dec_mem_write)) begin
            a_q  <= rs1_data;
            b_q  <= (dec_imm_op != IMM_NOP) ? imm_data : rs2_data;
            sd_q <= rs2_data;
          end
        end
        MC_EXEC: begin
          alu_q <= alu_result;
        end
        MC_MEM: begin
          if (dmem_ready && dec_mem_read) mdr <= dmem_rdata;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MULTICYCLE_CONTROL_PERF_EN
  // Cycle and retirement counters; every pc advance is exactly one retirement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles  <= '0;
      perf_retired <= '0;
    end else begin
      if (state != MC_TRAP) perf_cycles <= perf_cycles + 1'b1;
      if (adv_pc) perf_retired <= perf_retired + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control. The bench plays the
// role of decoder, regfile, ALU and both memories with fixed values per test.
module tb_multicycle_control;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [DW-1:0] imem_addr;
  logic          imem_ready;
  logic [DW-1:0] imem_rdata;
  logic [DW-1:0] instr;
  logic [2:0]    dec_alu_op;
  logic [2:0]    dec_imm_op;
  logic          dec_mem_read;
  logic          dec_mem_write;
  logic          dec_reg_write;
  logic [RW-1:0] dec_rd;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic [DW-1:0] imm_data;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_result;
  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ready;
  logic [DW-1:0] dmem_rdata;
  logic          rf_we;
  logic [RW-1:0] rf_rd;
  logic [DW-1:0] rf_wdata;
  logic          trap;
`ifdef MULTICYCLE_CONTROL_PERF_EN
  logic [DW-1:0] perf_cycles;
  logic [DW-1:0] perf_retired;
`endif

  int checks = 0;
  int passes = 0;

  multicycle_control #(.DATA_WIDTH(DW), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr(instr),
    .dec_alu_op(dec_alu_op), .dec_imm_op(dec_imm_op),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_reg_write(dec_reg_write), .dec_rd(dec_rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_data(imm_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
`ifdef MULTICYCLE_CONTROL_PERF_EN
    .perf_cycles(perf_cycles), .perf_retired(perf_retired),
`endif
    .trap(trap)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hard stop if anything ever stalls the sequence.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic set_idle_inputs();
    imem_ready    = 1'b1;
    imem_rdata    = 32'h0000_0013;
    dec_alu_op    = 3'd0;
    dec_imm_op    = 3'd0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_reg_write = 1'b0;
    dec_rd        = '0;
    rs1_data      = '0;
    rs2_data      = '0;
    imm_data      = '0;
    alu_result    = '0;
    dmem_ready    = 1'b1;
    dmem_rdata    = '0;
  endtask

  // Leaves the bench 1 unit into cycle 0 (first FETCH cycle).
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b0) $display("[TB] FAIL rst_imem_req: got %0b expected 0", imem_req);
    else passes++;
    checks++;
    if (dmem_req !== 1'b0 || rf_we !== 1'b0 || trap !== 1'b0)
      $display("[TB] FAIL rst_ctrl: got dmem_req=%0b rf_we=%0b trap=%0b expected 0/0/0", dmem_req, rf_we, trap);
    else passes++;
    checks++;
    if (imem_addr !== 32'h0 || instr !== 32'h0 || alu_a !== 32'h0)
      $display("[TB] FAIL rst_regs: got pc=%h ir=%h a=%h expected 0", imem_addr, instr, alu_a);
    else passes++;
  endtask

  task automatic test_alu();
    int we_cycles = 0;
    int we_at = -1;
    set_idle_inputs();
    dec_reg_write = 1'b1;
    dec_rd        = 5'd5;
    rs1_data      = 32'h10;
    rs2_data      = 32'h20;
    imm_data      = 32'hFFFF_FFFF;
    alu_result    = 32'h30;
    imem_rdata    = 32'h0020_82B3;
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      if (rf_we) begin
        we_cycles++;
        we_at = c;
      end
      if (c == 0) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0)
          $display("[TB] FAIL alu_fetch: got req=%0b addr=%h expected 1/0", imem_req, imem_addr);
        else passes++;
      end
      if (c == 1) begin
        checks++;
        if (instr !== 32'h0020_82B3) $display("[TB] FAIL alu_ir: got %h expected 002082b3", instr);
        else passes++;
      end
      if (c == 2) begin
        checks++;
        if (alu_a !== 32'h10 || alu_b !== 32'h20)
          $display("[TB] FAIL alu_operands: got a=%h b=%h expected 10/20", alu_a, alu_b);
        else passes++;
      end
      if (c == 3) begin
        checks++;
        if (rf_rd !== 5'd5 || rf_wdata !== 32'h30)
          $display("[TB] FAIL alu_wb: got rd=%0d data=%h expected 5/30", rf_rd, rf_wdata);
        else passes++;
      end
      if (c == 4) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4)
          $display("[TB] FAIL alu_next_pc: got req=%0b addr=%h expected 1/4", imem_req, imem_addr);
        else passes++;
      end
      next_cycle();
    end
    checks++;
    if (we_cycles != 1 || we_at != 3)
      $display("[TB] FAIL alu_rf_we: got %0d pulses at cycle %0d expected 1 at 3", we_cycles, we_at);
    else passes++;
  endtask

  task automatic test_load_stall();
    int we_cycles = 0;
    int stable = 0;
    set_idle_inputs();
    dec_mem_read  = 1'b1;
    dec_reg_write = 1'b1;
    dec_imm_op    = 3'd1;
    dec_rd        = 5'd7;
    rs1_data      = 32'h200;
    rs2_data      = 32'h999;
    imm_data      = 32'h4;
    alu_result    = 32'h204;
    dmem_rdata    = 32'hDEAD_BEEF;
    dmem_ready    = 1'b0;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      if (rf_we) we_cycles++;
      if (c == 2) begin
        checks++;
        if (alu_b !== 32'h4) $display("[TB] FAIL ld_imm_sel: got %h expected 4", alu_b);
        else passes++;
      end
      if (c >= 3 && c <= 6 && dmem_req === 1'b1 && dmem_we === 1'b0 && dmem_addr === 32'h204)
        stable++;
      if (c == 6) dmem_ready = 1'b1;
      if (c == 7) begin
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'hDEAD_BEEF)
          $display("[TB] FAIL ld_wb: got we=%0b rd=%0d data=%h expected 1/7/deadbeef", rf_we, rf_rd, rf_wdata);
        else passes++;
        checks++;
        if (dmem_req !== 1'b0) $display("[TB] FAIL ld_req_drop: got %0b expected 0", dmem_req);
        else passes++;
      end
      if (c == 8) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4)
          $display("[TB] FAIL ld_latency: got req=%0b addr=%h expected 1/4", imem_req, imem_addr);
        else passes++;
      end
      next_cycle();
    end
    checks++;
    if (stable != 4) $display("[TB] FAIL ld_stall_stable: got %0d cycles expected 4", stable);
    else passes++;
    checks++;
    if (we_cycles != 1) $display("[TB] FAIL ld_rf_we_count: got %0d expected 1", we_cycles);
    else passes++;
  endtask

  task automatic test_store();
    int we_cycles = 0;
    set_idle_inputs();
    dec_mem_write = 1'b1;
    dec_imm_op    = 3'd2;
    rs1_data      = 32'h100;
    imm_data      = 32'h8;
    rs2_data      = 32'h55;
    alu_result    = 32'h108;
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      if (rf_we) we_cycles++;
      if (c == 2) begin
        checks++;
        if (alu_a !== 32'h100 || alu_b !== 32'h8)
          $display("[TB] FAIL st_operands: got a=%h b=%h expected 100/8", alu_a, alu_b);
        else passes++;
      end
      if (c == 3) begin
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h108 || dmem_wdata !== 32'h55)
          $display("[TB] FAIL st_mem: got req=%0b we=%0b addr=%h wdata=%h expected 1/1/108/55",
                   dmem_req, dmem_we, dmem_addr, dmem_wdata);
        else passes++;
        checks++;
        if (imem_req !== 1'b0) $display("[TB] FAIL st_one_req: got imem_req=%0b expected 0", imem_req);
        else passes++;
      end
      if (c == 4) begin
        checks++;
        if (imem_addr !== 32'h4 || dmem_req !== 1'b0)
          $display("[TB] FAIL st_next: got addr=%h dmem_req=%0b expected 4/0", imem_addr, dmem_req);
        else passes++;
      end
      next_cycle();
    end
    checks++;
    if (we_cycles != 0) $display("[TB] FAIL st_rf_we: got %0d pulses expected 0", we_cycles);
    else passes++;
  endtask

  task automatic test_rd_zero();
    int we_cycles = 0;
    set_idle_inputs();
    dec_reg_write = 1'b1;
    dec_rd        = 5'd0;
    alu_result    = 32'h77;
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      if (rf_we) we_cycles++;
      if (c == 4) begin
        checks++;
        if (imem_addr !== 32'h4) $display("[TB] FAIL rd0_pc: got %h expected 4", imem_addr);
        else passes++;
      end
      next_cycle();
    end
    checks++;
    if (we_cycles != 0) $display("[TB] FAIL rd0_rf_we: got %0d pulses expected 0", we_cycles);
    else passes++;
  endtask

  task automatic test_trap();
    int req_cycles = 0;
    set_idle_inputs();
    dec_mem_read  = 1'b1;
    dec_mem_write = 1'b1;
    do_reset();
    next_cycle();
    checks++;
    if (trap !== 1'b0) $display("[TB] FAIL trap_early: got %0b expected 0", trap);
    else passes++;
    next_cycle();
    checks++;
    if (trap !== 1'b1) $display("[TB] FAIL trap_set: got %0b expected 1", trap);
    else passes++;
    for (int c = 0; c < 10; c++) begin
      if (imem_req || dmem_req) req_cycles++;
      next_cycle();
    end
    checks++;
    if (req_cycles != 0 || trap !== 1'b1 || imem_addr !== 32'h0)
      $display("[TB] FAIL trap_absorb: got req_cycles=%0d trap=%0b pc=%h expected 0/1/0", req_cycles, trap, imem_addr);
    else passes++;
    set_idle_inputs();
    do_reset();
    checks++;
    if (trap !== 1'b0 || imem_req !== 1'b1)
      $display("[TB] FAIL trap_clear: got trap=%0b req=%0b expected 0/1", trap, imem_req);
    else passes++;
  endtask

  task automatic test_reset_mid_mem();
    set_idle_inputs();
    dec_reg_write = 1'b1;
    dec_rd        = 5'd3;
    do_reset();
    for (int c = 0; c < 4; c++) next_cycle();
    dec_reg_write = 1'b1;
    dec_mem_read  = 1'b1;
    alu_result    = 32'h204;
    dmem_ready    = 1'b0;
    for (int c = 4; c < 7; c++) next_cycle();
    checks++;
    if (dmem_req !== 1'b1 || imem_addr !== 32'h4 || dmem_addr !== 32'h204)
      $display("[TB] FAIL mid_mem_setup: got req=%0b pc=%h addr=%h expected 1/4/204", dmem_req, imem_addr, dmem_addr);
    else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || imem_req !== 1'b0)
      $display("[TB] FAIL mid_mem_abort: got dmem_req=%0b imem_req=%0b expected 0/0", dmem_req, imem_req);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b1)
      $display("[TB] FAIL mid_mem_restart: got addr=%h req=%0b expected 0/1", imem_addr, imem_req);
    else passes++;
  endtask

  task automatic test_nop();
    set_idle_inputs();
    do_reset();
`ifdef MULTICYCLE_CONTROL_PERF_EN
    checks++;
    if (perf_retired !== 32'h0 || perf_cycles !== 32'h0)
      $display("[TB] FAIL perf_reset: got retired=%0d cycles=%0d expected 0/0", perf_retired, perf_cycles);
    else passes++;
`endif
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      if (c == 3) begin
        checks++;
        if (imem_addr !== 32'h4 || imem_req !== 1'b1)
          $display("[TB] FAIL nop_latency: got addr=%h req=%0b expected 4/1", imem_addr, imem_req);
        else passes++;
      end
    end
    checks++;
    if (imem_addr !== 32'hC) $display("[TB] FAIL nop_three: got %h expected c", imem_addr);
    else passes++;
`ifdef MULTICYCLE_CONTROL_PERF_EN
    checks++;
    if (perf_retired !== 32'd3 || perf_cycles !== 32'd9)
      $display("[TB] FAIL perf_count: got retired=%0d cycles=%0d expected 3/9", perf_retired, perf_cycles);
    else passes++;
`endif
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_alu();
    test_load_stall();
    test_store();
    test_rd_zero();
    test_trap();
    test_reset_mid_mem();
    test_nop();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
